// File: rtl/jump_motion_controller.sv
// Jump/steer sequencer for the player ball: detects frame ticks on the system clock and
// publishes per-frame signed X/Y steps, the jump state, a bounce count and game-over.
module jump_motion_controller #(
  parameter logic [9:0] JUMP_V    = 10'd12,
  parameter logic [9:0] GRAVITY   = 10'd1,
  parameter logic [3:0] GRAV_DIV  = 4'd4,
  parameter logic [9:0] MAX_FALL  = 10'd10,
  parameter logic [9:0] XSPEED    = 10'd2,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] DEATH_Y   = 10'd479,
  parameter logic [7:0] KEY_START = 8'd44
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] ball_s,
  input  logic       platform_hit,
  output logic [9:0] x_step,
  output logic [9:0] y_step,
  output logic       step_valid,
  output logic [2:0] state,
  output logic [7:0] bounce_cnt,
  output logic       game_over
);

  typedef enum logic [2:0] {
    MENU = 3'b000,
    RISE = 3'b001,
    FALL = 3'b010,
    LAND = 3'b011,
    OVER = 3'b100
  } state_t;

  state_t             cur_state, next_state;
  logic               fc_meta, fc_sync, fc_prev;
  logic               tick;
  logic signed [9:0]  vy, vy_next, vy_grav, vy_fall;
  logic        [3:0]  div, div_next, div_grav;
  logic        [7:0]  bounce_next;
  logic        [9:0]  x_next;
  logic               key_start, key_right, key_left;
  logic               motion, right_block, left_block, death;
  logic        [11:0] right_edge;

  // frame_clk comes from another domain; sync it and use only its rising edge.
  assign tick = fc_sync & ~fc_prev;

  // NOTE: every register here uses <= so all of them sample pre-edge values together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_meta    <= 1'b0;
      fc_sync    <= 1'b0;
      fc_prev    <= 1'b0;
      step_valid <= 1'b0;
      cur_state  <= MENU;
      vy         <= '0;
      div        <= '0;
      bounce_cnt <= '0;
      x_step     <= '0;
    end else begin
      fc_meta    <= frame_clk;
      fc_sync    <= fc_meta;
      fc_prev    <= fc_sync;
      step_valid <= tick;
      if (tick) begin
        cur_state  <= next_state;
        vy         <= vy_next;
        div        <= div_next;
        bounce_cnt <= bounce_next;
        x_step     <= x_next;
      end
    end
  end

  // One gravity event every GRAV_DIV ticks; the divider wraps on the event tick.
  always_comb begin
    div_grav = div + 4'd1;
    vy_grav  = vy;
    if (div == GRAV_DIV - 4'd1) begin
      div_grav = '0;
      vy_grav  = vy + $signed(GRAVITY);
    end
    vy_fall = (vy_grav > $signed(MAX_FALL)) ? $signed(MAX_FALL) : vy_grav;
  end

  assign key_start  = (keycode == KEY_START);
  assign key_right  = (keycode == 8'd7) || (keycode == 8'd79);
  assign key_left   = (keycode == 8'd4) || (keycode == 8'd80);
  assign death      = ({1'b0, ball_y} + {1'b0, ball_s}) >= {1'b0, DEATH_Y};
  assign right_edge = {2'b0, ball_x} + {2'b0, ball_s} + {2'b0, XSPEED};
  assign right_block = right_edge > {2'b0, X_MAX};
  assign left_block  = {1'b0, ball_x} < ({1'b0, X_MIN} + {1'b0, XSPEED});

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    next_state  = cur_state;
    vy_next     = vy;
    div_next    = div;
    bounce_next = bounce_cnt;
    case (cur_state)
      MENU: begin
        vy_next = '0;
        if (key_start) begin
          next_state = RISE;
          vy_next    = -$signed(JUMP_V);
          div_next   = '0;
        end
      end
      RISE: begin
        div_next = div_grav;
        vy_next  = vy_grav;
        if (vy_grav >= 10'sd0) next_state = FALL;
      end
      FALL: begin
        // Falling off the bottom wins over a simultaneous platform contact.
        if (death) begin
          next_state = OVER;
          vy_next    = '0;
        end else if (platform_hit) begin
          next_state  = LAND;
          vy_next     = '0;
          bounce_next = (bounce_cnt != 8'hFF) ? bounce_cnt + 8'd1 : bounce_cnt;
        end else begin
          div_next = div_grav;
          vy_next  = vy_fall;
        end
      end
      LAND: begin
        next_state = RISE;
        vy_next    = -$signed(JUMP_V);
        div_next   = '0;
      end
      OVER: begin
        vy_next = '0;
        if (key_start) begin
          next_state  = MENU;
          bounce_next = '0;
        end
      end
      default: begin
        next_state = MENU;
        vy_next    = '0;
        div_next   = '0;
      end
    endcase

    // Steering follows the state being entered, so MENU/OVER frames never move sideways.
    motion = (next_state == RISE) || (next_state == FALL) || (next_state == LAND);
    x_next = '0;
    if (motion) begin
      if (key_right && !right_block)     x_next = XSPEED;
      else if (key_left && !left_block)  x_next = -XSPEED;
    end
  end

  always_comb begin
    state     = cur_state;
    y_step    = vy;
    game_over = (cur_state == OVER);
  end

endmodule

// File: tb/tb_jump_motion_controller.sv
// Directed bench for jump_motion_controller: a behavioural model queues the expected
// outputs of every frame tick, which are popped and compared on each step_valid pulse.
module tb_jump_motion_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] ball_x, ball_y, ball_s;
  logic       platform_hit;
  logic [9:0] x_step, y_step;
  logic       step_valid;
  logic [2:0] state;
  logic [7:0] bounce_cnt;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  // Expected {state, x_step, y_step, bounce_cnt, game_over}.
  logic [31:0] exp_q[$];

  int m_st, m_vy, m_div, m_bc, m_x;

  jump_motion_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .ball_x(ball_x), .ball_y(ball_y), .ball_s(ball_s), .platform_hit(platform_hit),
    .x_step(x_step), .y_step(y_step), .step_valid(step_valid), .state(state),
    .bounce_cnt(bounce_cnt), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] observed();
    return {state, x_step, y_step, bounce_cnt, game_over};
  endfunction

  function automatic logic [31:0] model_out();
    logic [2:0] s;
    logic [9:0] x, y;
    logic [7:0] b;
    s = m_st[2:0];
    x = m_x[9:0];
    y = m_vy[9:0];
    b = m_bc[7:0];
    return {s, x, y, b, (m_st == 4)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_vy = 0; m_div = 0; m_bc = 0; m_x = 0;
  endtask

  task automatic model_gravity(input bit clamp);
    if (m_div == 3) begin
      m_div = 0;
      m_vy  = m_vy + 1;
    end else begin
      m_div = m_div + 1;
    end
    if (clamp && m_vy > 10) m_vy = 10;
  endtask

  task automatic model_tick(input int key, input int bx, input int by, input int bs, input bit hit);
    int dir;
    case (m_st)
      0: if (key == 44) begin m_st = 1; m_vy = -12; m_div = 0; end else m_vy = 0;
      1: begin model_gravity(1'b0); if (m_vy >= 0) m_st = 2; end
      2: begin
        if (by + bs >= 479) begin m_st = 4; m_vy = 0; end
        else if (hit) begin m_st = 3; m_vy = 0; if (m_bc < 255) m_bc++; end
        else model_gravity(1'b1);
      end
      3: begin m_st = 1; m_vy = -12; m_div = 0; end
      default: begin m_vy = 0; if (key == 44) begin m_st = 0; m_bc = 0; end end
    endcase
    dir = 0;
    if (key == 7 || key == 79) dir = 2;
    if (key == 4 || key == 80) dir = -2;
    if (dir > 0 && bx + bs + 2 > 639) dir = 0;
    if (dir < 0 && bx < 2) dir = 0;
    m_x = (m_st >= 1 && m_st <= 3) ? dir : 0;
  endtask

  // Called on a falling Clk edge; returns on a falling edge, ready for the next tick.
  task automatic do_tick(input logic [7:0] key, input logic [9:0] bx, input logic [9:0] by,
                         input logic [9:0] bs, input logic hit, input string tag);
    bit seen;
    logic [31:0] e;
    keycode = key; ball_x = bx; ball_y = by; ball_s = bs; platform_hit = hit;
    frame_clk = 1'b1;
    model_tick(int'(key), int'(bx), int'(by), int'(bs), hit);
    exp_q.push_back(model_out());
    @(negedge Clk);
    frame_clk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge Clk);
      seen = step_valid;
    end
    check({"valid_", tag}, {31'd0, seen}, 32'd1);
    e = exp_q.pop_front();
    if (seen) begin
      check(tag, observed(), e);
      @(negedge Clk);
      check({"pulse_", tag}, {31'd0, step_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] steer_key [5];
    logic [9:0] steer_x   [5];
    int n;
    steer_key = '{8'd0, 8'd7, 8'd79, 8'd4, 8'd80};
    steer_x   = '{10'd100, 10'd100, 10'd636, 10'd1, 10'd300};

    Reset = 1'b1; frame_clk = 1'b0; keycode = '0;
    ball_x = 10'd100; ball_y = 10'd100; ball_s = 10'd4; platform_hit = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); frame_clk = 1'b1;
      @(negedge Clk); frame_clk = 1'b0;
    end
    check("reset_outputs", {observed(), 1'b0} | {31'd0, step_valid}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("idle_no_valid", {31'd0, step_valid}, 32'd0);
    end

    // Idle menu tick, then start the jump.
    do_tick(8'd0, 10'd100, 10'd100, 10'd4, 1'b0, "menu_idle");
    do_tick(8'd44, 10'd100, 10'd100, 10'd4, 1'b0, "start");
    check("start_vy", {22'd0, y_step}, {22'd0, 10'h3F4});

    // Full rise with steering patterns, including both walls.
    for (int i = 0; i < 48; i++)
      do_tick(steer_key[i % 5], steer_x[i % 5], 10'd100, 10'd4, 1'b0, "rise");
    check("rise_to_fall", {19'd0, state, y_step}, {19'd0, 3'b010, 10'd0});

    // Long fall, vy must saturate.
    for (int i = 0; i < 60; i++)
      do_tick(8'd0, 10'd100, 10'd100, 10'd4, 1'b0, "fall");
    check("fall_saturated", {22'd0, y_step}, 32'd10);

    // Repeated landings, past the bounce-count saturation point.
    for (int b = 0; b < 257; b++) begin
      do_tick(8'd0, 10'd100, 10'd100, 10'd4, 1'b1, "land");
      do_tick(8'd0, 10'd100, 10'd100, 10'd4, 1'b1, "land_rise");
      n = 0;
      while (m_st != 2 && n < 60) begin
        do_tick(8'd0, 10'd100, 10'd100, 10'd4, 1'b0, "bounce_rise");
        n++;
      end
    end
    check("bounce_sat", {24'd0, bounce_cnt}, 32'd255);

    // Death line has priority over a platform hit on the same tick.
    do_tick(8'd0, 10'd100, 10'd475, 10'd4, 1'b1, "death");
    check("game_over", {28'd0, state, game_over}, {28'd0, 3'b100, 1'b1});
    do_tick(8'd44, 10'd100, 10'd100, 10'd4, 1'b0, "restart");
    check("restart_clear", {21'd0, state, bounce_cnt}, 32'd0);

    // Right-wall block, then a reset in the middle of a rise.
    do_tick(8'd44, 10'd100, 10'd100, 10'd4, 1'b0, "start2");
    do_tick(8'd7, 10'd637, 10'd100, 10'd4, 1'b0, "right_wall");
    do_tick(8'd7, 10'd100, 10'd100, 10'd4, 1'b0, "right_free");
    Reset = 1'b1;
    #1;
    check("mid_reset", {observed(), 1'b0} | {31'd0, step_valid}, 32'd0);
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    do_tick(8'd7, 10'd637, 10'd100, 10'd4, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
